// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder/subtractor.
package serial_adder_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  function automatic int CNT_W(input int w);
    return $clog2(w);
  endfunction

endpackage

// File: rtl/serial_adder_fa_cell.sv
// Combinational one-bit full adder used as the single arithmetic cell.
module fa_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic s_o,
  output logic cout_o
);

  assign s_o    = a_i ^ b_i ^ cin_i;
  assign cout_o = (a_i & b_i) | (a_i & cin_i) | (b_i & cin_i);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial W-bit adder/subtractor, one bit per clock, start/busy/done handshake.
// Define SERIAL_ADDER_OVF_EN to add the signed-overflow output ovf.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         sub,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] sum,
  output logic         cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic         ovf
`endif
);

  localparam int CW = CNT_W(W);
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [W-1:0]   res_q, res_d;
  logic [W-1:0]   sum_q, sum_d;
  logic           carry_q, carry_d;
  logic           cout_q, cout_d;
  logic           done_q, done_d;
  logic           fa_s, fa_co;
  logic           accept, last_bit;

  assign accept   = (state_q == IDLE) && start;
  assign last_bit = (state_q == RUN) && (cnt_q == CNT_LAST);

  fa_cell u_fa (
    .a_i   (a_q[0]),
    .b_i   (b_q[0]),
    .cin_i (carry_q),
    .s_o   (fa_s),
    .cout_o(fa_co)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_bit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == RUN);
  end

  // Subtraction is a + ~b + 1: invert B on load and seed the carry with sub.
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    if (accept) begin
      a_d     = a;
      b_d     = b ^ {W{sub}};
      carry_d = sub;
      cnt_d   = '0;
    end else if (state_q == RUN) begin
      a_d     = a_q >> 1;
      b_d     = b_q >> 1;
      carry_d = fa_co;
      res_d   = {fa_s, res_q[W-1:1]};
      if (last_bit) begin
        done_d = 1'b1;
        sum_d  = {fa_s, res_q[W-1:1]};
        cout_d = fa_co;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign done = done_q;

`ifdef SERIAL_ADDER_OVF_EN
  logic ovf_q, ovf_d;

  // On the final bit carry_q is the carry into the MSB and fa_co the carry out of it.
  always_comb begin
    ovf_d = ovf_q;
    if (last_bit) ovf_d = carry_q ^ fa_co;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder (W=8), optional ovf checks.
module tb_serial_adder;

  logic       clk;
  logic       rst;
  logic       start;
  logic       sub;
  logic [7:0] a;
  logic [7:0] b;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic       ovf;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  serial_adder #(.W(8)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .sub  (sub),
    .a    (a),
    .b    (b),
    .busy (busy),
    .done (done),
    .sum  (sum),
    .cout (cout)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf  (ovf)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive a start for one edge, then scramble the operand inputs.
  task automatic issue(input logic [7:0] ai, input logic [7:0] bi, input logic si);
    start = 1'b1;
    a     = ai;
    b     = bi;
    sub   = si;
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = ~ai;
    b     = bi ^ 8'hA5;
    sub   = ~si;
  endtask

  // Count edges after the start edge until done is seen; -1 if it never comes.
  task automatic wait_done(output int edges);
    edges = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        edges = i;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst   = 1'b1;
    start = 1'b0;
    sub   = 1'b0;
    a     = 8'h00;
    b     = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: busy=%b done=%b, required busy=0 done=0", busy, done);
    end
    n_cmp++;
    if (sum !== 8'h00 || cout !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_data: sum=%h cout=%b, required sum=00 cout=0", sum, cout);
    end
`ifdef SERIAL_ADDER_OVF_EN
    n_cmp++;
    if (ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ovf: ovf=%b, required 0", ovf);
    end
`endif
    $display("reset: busy=%b done=%b sum=%h cout=%b", busy, done, sum, cout);
  endtask

  task automatic test_add;
    int edges;
    issue(8'h5A, 8'h3C, 1'b0);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL add_busy: busy=%b, required 1", busy);
    end
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (sum !== 8'h00) begin
      n_fail++;
      $display("FAIL add_sum_stable: sum=%h mid-run, required 00", sum);
    end
    wait_done(edges);
    edges = edges + 3;
    n_cmp++;
    if (edges + 1 !== 9) begin
      n_fail++;
      $display("FAIL add_latency: %0d edges, required 9", edges + 1);
    end
    n_cmp++;
    if (sum !== 8'h96 || cout !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL add_result: sum=%h cout=%b busy=%b, required 96 0 0", sum, cout, busy);
    end
`ifdef SERIAL_ADDER_OVF_EN
    n_cmp++;
    if (ovf !== 1'b1) begin
      n_fail++;
      $display("FAIL add_ovf: ovf=%b, required 1", ovf);
    end
`endif
    @(posedge clk);
    #1;
    n_cmp++;
    if (done !== 1'b0 || sum !== 8'h96) begin
      n_fail++;
      $display("FAIL add_done_pulse: done=%b sum=%h, required 0 96", done, sum);
    end
    $display("add 5a+3c: sum=%h cout=%b latency=%0d", sum, cout, edges + 1);
  endtask

  task automatic test_add_carry;
    int edges;
    issue(8'hFF, 8'h01, 1'b0);
    wait_done(edges);
    n_cmp++;
    if (edges !== 8 || sum !== 8'h00 || cout !== 1'b1) begin
      n_fail++;
      $display("FAIL add_carry: edges=%0d sum=%h cout=%b, required 8 00 1", edges, sum, cout);
    end
`ifdef SERIAL_ADDER_OVF_EN
    n_cmp++;
    if (ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL add_carry_ovf: ovf=%b, required 0", ovf);
    end
`endif
    $display("add ff+01: sum=%h cout=%b", sum, cout);
  endtask

  task automatic test_subtract;
    int edges;
    issue(8'h10, 8'h20, 1'b1);
    wait_done(edges);
    n_cmp++;
    if (edges !== 8 || sum !== 8'hF0 || cout !== 1'b0) begin
      n_fail++;
      $display("FAIL sub_borrow: edges=%0d sum=%h cout=%b, required 8 f0 0", edges, sum, cout);
    end
`ifdef SERIAL_ADDER_OVF_EN
    n_cmp++;
    if (ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL sub_borrow_ovf: ovf=%b, required 0", ovf);
    end
`endif
    $display("sub 10-20: sum=%h cout=%b", sum, cout);
    @(posedge clk);
    #1;
    issue(8'h80, 8'h01, 1'b1);
    wait_done(edges);
    n_cmp++;
    if (edges !== 8 || sum !== 8'h7F || cout !== 1'b1) begin
      n_fail++;
      $display("FAIL sub_nobrw: edges=%0d sum=%h cout=%b, required 8 7f 1", edges, sum, cout);
    end
`ifdef SERIAL_ADDER_OVF_EN
    n_cmp++;
    if (ovf !== 1'b1) begin
      n_fail++;
      $display("FAIL sub_nobrw_ovf: ovf=%b, required 1", ovf);
    end
`endif
    $display("sub 80-01: sum=%h cout=%b", sum, cout);
  endtask

  task automatic test_reset_mid;
    int pulses;
    int edges;
    @(posedge clk);
    #1;
    issue(8'h33, 8'h44, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || sum !== 8'h00 || cout !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: busy=%b done=%b sum=%h cout=%b, required 0 0 00 0",
               busy, done, sum, cout);
    end
`ifdef SERIAL_ADDER_OVF_EN
    n_cmp++;
    if (ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_ovf: ovf=%b, required 0", ovf);
    end
`endif
    @(posedge clk);
    #1;
    rst    = 1'b0;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1 || busy === 1'b1) pulses++;
    end
    n_cmp++;
    if (pulses !== 0) begin
      n_fail++;
      $display("FAIL reset_mid_quiet: %0d active cycles after reset, required 0", pulses);
    end
    issue(8'h21, 8'h12, 1'b0);
    wait_done(edges);
    n_cmp++;
    if (edges !== 8 || sum !== 8'h33 || cout !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_next: edges=%0d sum=%h cout=%b, required 8 33 0", edges, sum, cout);
    end
    $display("reset mid-run then 21+12: sum=%h cout=%b", sum, cout);
  endtask

  task automatic test_start_busy;
    int edges;
    @(posedge clk);
    #1;
    issue(8'h12, 8'h34, 1'b0);
    edges = -1;
    for (int i = 1; i <= 40; i++) begin
      if (i == 4) begin
        start = 1'b1;
        a     = 8'hFF;
        b     = 8'hFF;
        sub   = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        edges = i;
        break;
      end
    end
    start = 1'b0;
    n_cmp++;
    if (edges !== 8 || sum !== 8'h46 || cout !== 1'b0) begin
      n_fail++;
      $display("FAIL start_busy: edges=%0d sum=%h cout=%b, required 8 46 0", edges, sum, cout);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL start_busy_idle: busy=%b after done, required 0", busy);
    end
    $display("start-while-busy 12+34: sum=%h cout=%b", sum, cout);
  endtask

  task automatic test_back_to_back;
    int edges;
    int bad;
    @(posedge clk);
    #1;
    issue(8'h5A, 8'h3C, 1'b0);
    wait_done(edges);
    n_cmp++;
    if (edges !== 8 || sum !== 8'h96) begin
      n_fail++;
      $display("FAIL b2b_first: edges=%0d sum=%h, required 8 96", edges, sum);
    end
    issue(8'h01, 8'h02, 1'b0);
    n_cmp++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_accept: busy=%b done=%b, required 1 0", busy, done);
    end
    bad = 0;
    for (int i = 1; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (sum !== 8'h96 || done !== 1'b0) bad++;
    end
    n_cmp++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL b2b_hold: %0d cycles with sum!=96 or early done, required 0", bad);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (done !== 1'b1 || sum !== 8'h03 || cout !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_second: done=%b sum=%h cout=%b, required 1 03 0", done, sum, cout);
    end
    $display("back-to-back 5a+3c then 01+02: sum=%h cout=%b", sum, cout);
  endtask

  initial begin
    test_reset();
    test_add();
    test_add_carry();
    test_subtract();
    test_reset_mid();
    test_start_busy();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
# serial_adder

Parametrised bit-serial adder/subtractor that computes a W-bit sum one bit per clock, using a single full-adder cell and a carry flip-flop. A start/busy/done handshake controls it. It extends the combinational one-bit full adder into an area-lean multi-bit datapath for control paths where latency matters less than gate count.

## Interface
- W, default 8: operand and result width in bits, legal range W >= 2.
- clk, input, 1: sole clock, rising-edge active.
- rst, input, 1: asynchronous, active-high reset.
- start, input, 1: request a new operation; sampled only in IDLE.
- sub, input, 1: 0 selects a+b, 1 selects a-b; sampled with start.
- a, input, W: first operand; sampled with start.
- b, input, W: second operand; sampled with start.
- busy, output, 1: high while an operation is in progress.
- done, output, 1: one-cycle pulse when the result is valid.
- sum, output, W: result; held stable from done until the next accepted start.
- cout, output, 1: final carry-out; for subtraction, 1 means no borrow (a >= b unsigned).
- ovf, output, 1: signed overflow; present only with SERIAL_ADDER_OVF_EN.
- The block has one clock. Reset is asynchronous and active-high. The ports are named clk and rst.

## Operation
- FSM states: IDLE and RUN.
- **IDLE:**
  - start=1 latches a into shift register A.
  - It latches b^{W{sub}} into shift register B.
  - It loads carry FF = sub and clears the bit counter.
  - The FSM then moves to RUN.
- **RUN:** each cycle,
  - the full-adder cell takes A[0], B[0] and carry;
  - its sum bit shifts into the result register MSB-first-in, so after W shifts bit 0 sits at sum[0];
  - A and B shift right, carry FF takes the cell's cout, and the counter increments.
- **End of RUN:** when the counter reaches W-1 and that bit completes, the FSM returns to IDLE.
  - On that edge, done pulses and cout is registered.
- **Result:** sum equals (a + b) mod 2^W, or (a - b) mod 2^W in subtract mode.
- **Start while busy:** ignored. No queuing and no error flag.
- **Start in the done cycle:** accepted, since the FSM is already in IDLE. This allows back-to-back operations.
- **Operands:** a, b and sub may change freely after the start edge without affecting the result.
- **Reset mid-operation:**
  - The operation is abandoned and the FSM goes to IDLE.
  - busy, done, sum, cout and ovf are cleared. No done is produced.

## Timing
- **Reset values:** busy=0, done=0, sum=0, cout=0, ovf=0, state=IDLE.
- **Handshake sequence:**
  - Start is sampled high at edge k.
  - busy=1 from after edge k through edge k+W.
  - done=1 and busy=0 for the cycle after edge k+W.
- **Latency:** W+1 clock edges from the start sample to done observed high; throughput is one operation per W+1 cycles.
- **Output stability:** sum, cout and ovf update only on the done edge.
  - They are not updated during RUN, because the internal result shift register is separate from the sum output register.
- **Counter:** $clog2(W) bits wide; the terminal count is W-1. Wrap is never reached.

## Configuration
- SERIAL_ADDER_OVF_EN defined:
  - The ovf port exists.
  - ovf = carry into the MSB XOR carry out of the MSB, captured on the final RUN cycle and registered with done.
- Not defined:
  - The ovf port and its logic are absent.
  - All other behaviour is identical.

## Structure
- serial_adder_pkg holds:
  - the state enum (IDLE, RUN);
  - a CNT_W(W) helper constant function returning $clog2(W).
- The block has one sub-module, fa_cell: a combinational one-bit full adder (sum = a^b^cin, cout = majority).
  - It is instantiated once in the datapath.

## Test plan
- **Reset:** W=8; assert rst mid-RUN after 3 bits -> busy=0, done never pulses, sum=0, cout=0; the next start computes correctly.
- **Add:** a=8'h5A, b=8'h3C, sub=0 -> done 9 edges after start, sum=8'h96, cout=0, ovf=1.
- **Add with carry:** a=8'hFF, b=8'h01, sub=0 -> sum=8'h00, cout=1, ovf=0.
- **Subtract:** a=8'h10, b=8'h20, sub=1 -> sum=8'hF0, cout=0 (borrow), ovf=0.
  - Then a=8'h80, b=8'h01 -> sum=8'h7F, cout=1, ovf=1.
- **Start while busy:** start pulsed 4 cycles into RUN with different operands -> ignored; the original result is delivered.
- **Back-to-back:** second start held high during the done cycle with a=8'h01, b=8'h02 -> its busy rises on the next edge, sum=8'h03 after a further 9 edges.
  - The first result stays on sum until then.
